// File: rtl/lstm_elemwise_engine_pkg.sv
// Shared types, width derivations and saturating fixed-point helpers for the LSTM
// elementwise engine. Arithmetic helpers work on a 64-bit signed carrier.
package lstm_elemwise_engine_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACT  = 3'd1,
        ZI   = 3'd2,
        CF   = 3'd3,
        HO   = 3'd4,
        DONE = 3'd5
    } engState_t;

    typedef logic signed [63:0] wide_t;

    function automatic int bitWidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int vecWidth(input int n, input int qn, input int qm);
        return n * bitWidth(qn, qm);
    endfunction

    function automatic int oneVal(input int qm);
        return 1 << qm;
    endfunction

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    // Clamp to the signed range of a bw-bit word.
    function automatic wide_t satRange(input wide_t v, input int bw);
        wide_t hi, lo, r;
        hi = (wide_t'(1) <<< (bw - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        r = v;
        if (v > hi) r = hi;
        else if (v < lo) r = lo;
        return r;
    endfunction

    // Full product, floor shift by qm, then saturate.
    function automatic wide_t mulSat(input wide_t a, input wide_t b, input int qm, input int bw);
        wide_t p;
        p = a * b;
        return satRange(p >>> qm, bw);
    endfunction

    function automatic wide_t satAdd(input wide_t a, input wide_t b, input int bw);
        return satRange(a + b, bw);
    endfunction

endpackage

// File: rtl/lstm_elemwise_engine_pwl_act.sv
// Piecewise-linear activation: mode 0 = hard sigmoid, mode 1 = hard tanh.
// Purely combinational clamp unit on one fixed-point element.
module pwl_act
    import lstm_elemwise_engine_pkg::*;
#(
    parameter int QN = 6,
    parameter int QM = 11
) (
    input  logic               mode,
    input  logic signed [QN+QM:0] x,
    output logic signed [QN+QM:0] y
);

    localparam int BW = bitWidth(QN, QM);

    wide_t xw, one, raw, lo, clamped;

    always_comb begin
        xw  = wide_t'(x);
        one = wide_t'(oneVal(QM));
        if (mode) begin
            raw = xw;
            lo  = -one;
        end else begin
            raw = (xw >>> 2) + (one >>> 1);
            lo  = '0;
        end
        clamped = raw;
        if (raw < lo) clamped = lo;
        else if (raw > one) clamped = one;
    end

    assign y = clamped[BW-1:0];

endmodule

// File: rtl/lstm_elemwise_engine.sv
// LSTM cell update c_t = z*i + c_{t-1}*f, h_t = tanh(c_t)*o, time-shared over LANES
// multiplier lanes, four cycles (ACT, ZI, CF, HO) per group of LANES elements.
module lstm_elemwise_engine
    import lstm_elemwise_engine_pkg::*;
#(
    parameter int HIDDEN_SZ = 16,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int LANES     = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    gate_z,
    input  logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    gate_i,
    input  logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    gate_f,
    input  logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    gate_o,
    input  logic                                      clear_state,
    // Transfers happen on an edge where valid && ready; ready never depends on valid.
    input  logic                                      gates_valid,
    output logic                                      gates_ready,
    output logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    h_out,
    output logic [vecWidth(HIDDEN_SZ, QN, QM)-1:0]    c_out,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      busy
);

    localparam int BW     = bitWidth(QN, QM);
    localparam int VEC_W  = vecWidth(HIDDEN_SZ, QN, QM);
    localparam int GROUPS = HIDDEN_SZ / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? log2(GROUPS) : 1;

    if (HIDDEN_SZ % LANES != 0) begin : gBadLanes
        $error("lstm_elemwise_engine: HIDDEN_SZ must be a multiple of LANES");
    end

    engState_t state, nextState;

    logic [VEC_W-1:0] zLat, iLat, fLat, oLat;
    logic             clearLat;
    logic [CNT_W-1:0] grp;
    logic [VEC_W-1:0] cStore, hStore;
    logic             lastGroup;

    logic signed [BW-1:0] cLane [LANES];
    logic signed [BW-1:0] hLane [LANES];

    assign lastGroup = (grp == CNT_W'(GROUPS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (gates_valid) nextState = ACT;
            ACT:     nextState = ZI;
            ZI:      nextState = CF;
            CF:      nextState = HO;
            HO:      nextState = lastGroup ? DONE : ACT;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign gates_ready = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign h_out       = hStore;
    assign c_out       = cStore;

    // Per-lane datapath; the element handled by lane l is grp*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : gLane
        logic signed [BW-1:0] preZ, preI, preF, preO;
        logic signed [BW-1:0] nZ, nI, nF, nO, tanhC, cPrev;
        logic signed [BW-1:0] actZ, actI, actF, actO, zi, cNew;
        wide_t ziW, fcW, cW, hW;
        int base;

        always_comb begin
            base  = (int'(grp) * LANES + l) * BW;
            preZ  = zLat[base +: BW];
            preI  = iLat[base +: BW];
            preF  = fLat[base +: BW];
            preO  = oLat[base +: BW];
            cPrev = clearLat ? '0 : cStore[base +: BW];
            ziW   = mulSat(wide_t'(actZ), wide_t'(actI), QM, BW);
            fcW   = mulSat(wide_t'(cPrev), wide_t'(actF), QM, BW);
            cW    = satAdd(wide_t'(zi), fcW, BW);
            hW    = mulSat(wide_t'(tanhC), wide_t'(actO), QM, BW);
        end

        pwl_act #(.QN(QN), .QM(QM)) uActZ (.mode(1'b1), .x(preZ), .y(nZ));
        pwl_act #(.QN(QN), .QM(QM)) uActI (.mode(1'b0), .x(preI), .y(nI));
        pwl_act #(.QN(QN), .QM(QM)) uActF (.mode(1'b0), .x(preF), .y(nF));
        pwl_act #(.QN(QN), .QM(QM)) uActO (.mode(1'b0), .x(preO), .y(nO));
        pwl_act #(.QN(QN), .QM(QM)) uActC (.mode(1'b1), .x(cNew), .y(tanhC));

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                actZ <= '0;
                actI <= '0;
                actF <= '0;
                actO <= '0;
                zi   <= '0;
                cNew <= '0;
            end else begin
                case (state)
                    ACT: begin
                        actZ <= nZ;
                        actI <= nI;
                        actF <= nF;
                        actO <= nO;
                    end
                    ZI:      zi   <= ziW[BW-1:0];
                    CF:      cNew <= cW[BW-1:0];
                    default: ;
                endcase
            end
        end

        assign cLane[l] = cW[BW-1:0];
        assign hLane[l] = hW[BW-1:0];
    end

    // Outputs for groups not yet reached keep the previous sample's values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zLat     <= '0;
            iLat     <= '0;
            fLat     <= '0;
            oLat     <= '0;
            clearLat <= 1'b0;
            grp      <= '0;
            cStore   <= '0;
            hStore   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gates_valid) begin
                        zLat     <= gate_z;
                        iLat     <= gate_i;
                        fLat     <= gate_f;
                        oLat     <= gate_o;
                        clearLat <= clear_state;
                        grp      <= '0;
                    end
                end
                CF: begin
                    for (int l = 0; l < LANES; l++)
                        cStore[(int'(grp) * LANES + l) * BW +: BW] <= cLane[l];
                end
                HO: begin
                    for (int l = 0; l < LANES; l++)
                        hStore[(int'(grp) * LANES + l) * BW +: BW] <= hLane[l];
                    if (!lastGroup) grp <= grp + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_elemwise_engine.sv
// Directed bench for lstm_elemwise_engine with HIDDEN_SZ=4, LANES=2, Q6.11 (ONE=2048).
`timescale 1ns/1ps
module tb_lstm_elemwise_engine;

    localparam int HIDDEN_SZ = 4;
    localparam int QN        = 6;
    localparam int QM        = 11;
    localparam int LANES     = 2;
    localparam int BW        = 18;
    localparam int VW        = 72;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] gate_z = '0, gate_i = '0, gate_f = '0, gate_o = '0;
    logic          clear_state = 1'b0;
    logic          gates_valid = 1'b0;
    logic          gates_ready;
    logic [VW-1:0] h_out, c_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    int nCompared   = 0;
    int nMismatched = 0;

    lstm_elemwise_engine #(
        .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM), .LANES(LANES)
    ) dut (
        .clock(clock), .reset(reset),
        .gate_z(gate_z), .gate_i(gate_i), .gate_f(gate_f), .gate_o(gate_o),
        .clear_state(clear_state), .gates_valid(gates_valid), .gates_ready(gates_ready),
        .h_out(h_out), .c_out(c_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [VW-1:0] rep(input int v);
        logic [BW-1:0] e;
        e = v[BW-1:0];
        return {HIDDEN_SZ{e}};
    endfunction

    function automatic logic [VW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [BW-1:0] a, b, c, d;
        a = e0[BW-1:0];
        b = e1[BW-1:0];
        c = e2[BW-1:0];
        d = e3[BW-1:0];
        return {d, c, b, a};
    endfunction

    // Drives one sample, returns edges from the accept edge to out_valid.
    task automatic sendSample(input logic [VW-1:0] z, input logic [VW-1:0] i,
                              input logic [VW-1:0] f, input logic [VW-1:0] o,
                              input logic clr, output int latency, output bit timedOut);
        int waitCnt;
        gate_z = z;
        gate_i = i;
        gate_f = f;
        gate_o = o;
        clear_state = clr;
        gates_valid = 1'b1;
        waitCnt = 0;
        while (!gates_ready && waitCnt < 50) begin
            @(posedge clock); #1;
            waitCnt++;
        end
        @(posedge clock); #1;
        gates_valid = 1'b0;
        latency = 0;
        while (!out_valid && latency < 100) begin
            @(posedge clock); #1;
            latency++;
        end
        timedOut = !out_valid;
    endtask

    task automatic releaseOutput;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        nCompared++; if (gates_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b expected 1", gates_ready); end
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nCompared++; if (h_out !== '0) begin nMismatched++; $display("FAIL reset_h: got %h expected 0", h_out); end
        nCompared++; if (c_out !== '0) begin nMismatched++; $display("FAIL reset_c: got %h expected 0", c_out); end
        reset = 1'b0;
        @(posedge clock); #1;
        nCompared++; if (gates_ready !== 1'b1 || busy !== 1'b0) begin nMismatched++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", gates_ready, busy); end
    endtask

    task automatic test_zero;
        int lat; bit to;
        sendSample(rep(0), rep(0), rep(0), rep(0), 1'b1, lat, to);
        nCompared++; if (lat !== 8) begin nMismatched++; $display("FAIL zero_latency: got %0d expected 8", lat); end
        nCompared++; if (c_out !== rep(0)) begin nMismatched++; $display("FAIL zero_c: got %h expected %h", c_out, rep(0)); end
        nCompared++; if (h_out !== rep(0)) begin nMismatched++; $display("FAIL zero_h: got %h expected %h", h_out, rep(0)); end
        nCompared++; if (gates_ready !== 1'b0) begin nMismatched++; $display("FAIL zero_ready_in_done: got %b expected 0", gates_ready); end
        releaseOutput();
        nCompared++; if (out_valid !== 1'b0 || gates_ready !== 1'b1) begin nMismatched++; $display("FAIL zero_release: got valid=%b ready=%b expected 0/1", out_valid, gates_ready); end
    endtask

    task automatic test_basic;
        int lat; bit to;
        sendSample(rep(2048), rep(8192), rep(0), rep(8192), 1'b1, lat, to);
        nCompared++; if (to !== 1'b0) begin nMismatched++; $display("FAIL basic_clr_timeout: got %b expected 0", to); end
        nCompared++; if (c_out !== rep(2048)) begin nMismatched++; $display("FAIL basic_clr_c: got %h expected %h", c_out, rep(2048)); end
        nCompared++; if (h_out !== rep(2048)) begin nMismatched++; $display("FAIL basic_clr_h: got %h expected %h", h_out, rep(2048)); end
        releaseOutput();
        sendSample(rep(2048), rep(8192), rep(0), rep(8192), 1'b0, lat, to);
        nCompared++; if (c_out !== rep(3072)) begin nMismatched++; $display("FAIL basic_keep_c: got %h expected %h", c_out, rep(3072)); end
        nCompared++; if (h_out !== rep(2048)) begin nMismatched++; $display("FAIL basic_keep_h: got %h expected %h", h_out, rep(2048)); end
        releaseOutput();
    endtask

    task automatic test_negative;
        int lat; bit to;
        sendSample(rep(-2048), rep(8192), rep(0), rep(8192), 1'b1, lat, to);
        nCompared++; if (c_out !== rep(-2048)) begin nMismatched++; $display("FAIL neg_c: got %h expected %h", c_out, rep(-2048)); end
        nCompared++; if (h_out !== rep(-2048)) begin nMismatched++; $display("FAIL neg_h: got %h expected %h", h_out, rep(-2048)); end
        releaseOutput();
    endtask

    // Distinct values per element exercise lane and group placement plus floor rounding.
    task automatic test_mixed;
        int lat; bit to;
        sendSample(pack4(-3, 1000, -2048, 5000), pack4(1, 8192, 8192, 8192),
                   rep(0), rep(8192), 1'b1, lat, to);
        nCompared++; if (c_out !== pack4(-2, 1000, -2048, 2048)) begin nMismatched++; $display("FAIL mixed_c: got %h expected %h", c_out, pack4(-2, 1000, -2048, 2048)); end
        nCompared++; if (h_out !== pack4(-2, 1000, -2048, 2048)) begin nMismatched++; $display("FAIL mixed_h: got %h expected %h", h_out, pack4(-2, 1000, -2048, 2048)); end
        releaseOutput();
    endtask

    task automatic test_saturation;
        int lat; bit to; int expC;
        for (int n = 1; n <= 70; n++) begin
            sendSample(rep(2048), rep(8192), rep(8192), rep(8192), (n == 1), lat, to);
            expC = (2048 * n > 131071) ? 131071 : 2048 * n;
            nCompared++; if (c_out !== rep(expC)) begin nMismatched++; $display("FAIL sat_c[%0d]: got %h expected %h", n, c_out, rep(expC)); end
            nCompared++; if (h_out !== rep(2048)) begin nMismatched++; $display("FAIL sat_h[%0d]: got %h expected %h", n, h_out, rep(2048)); end
            releaseOutput();
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit to;
        sendSample(rep(2048), rep(8192), rep(0), rep(8192), 1'b1, lat, to);
        gate_z = rep(0);
        gate_i = rep(0);
        gate_f = rep(8192);
        gate_o = rep(0);
        clear_state = 1'b0;
        gates_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("FAIL hold_valid[%0d]: got %b expected 1", k, out_valid); end
            nCompared++; if (h_out !== rep(2048)) begin nMismatched++; $display("FAIL hold_h[%0d]: got %h expected %h", k, h_out, rep(2048)); end
            nCompared++; if (c_out !== rep(2048)) begin nMismatched++; $display("FAIL hold_c[%0d]: got %h expected %h", k, c_out, rep(2048)); end
            nCompared++; if (gates_ready !== 1'b0) begin nMismatched++; $display("FAIL hold_ready[%0d]: got %b expected 0", k, gates_ready); end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        nCompared++; if (out_valid !== 1'b0 || gates_ready !== 1'b1 || busy !== 1'b0) begin nMismatched++; $display("FAIL same_cycle_not_accepted: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, gates_ready, busy); end
        @(posedge clock); #1;
        gates_valid = 1'b0;
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("FAIL next_cycle_accept: got busy=%b expected 1", busy); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        nCompared++; if (lat !== 8) begin nMismatched++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
        nCompared++; if (c_out !== rep(2048)) begin nMismatched++; $display("FAIL b2b_c: got %h expected %h", c_out, rep(2048)); end
        nCompared++; if (h_out !== rep(1024)) begin nMismatched++; $display("FAIL b2b_h: got %h expected %h", h_out, rep(1024)); end
        releaseOutput();
    endtask

    task automatic test_reset_mid;
        int lat; bit to; int waitCnt;
        gate_z = rep(2048);
        gate_i = rep(8192);
        gate_f = rep(8192);
        gate_o = rep(8192);
        clear_state = 1'b0;
        gates_valid = 1'b1;
        waitCnt = 0;
        while (!gates_ready && waitCnt < 50) begin
            @(posedge clock); #1;
            waitCnt++;
        end
        @(posedge clock); #1;
        gates_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        nCompared++; if (c_out[17:0] !== 18'd4096) begin nMismatched++; $display("FAIL mid_group0_c: got %0d expected 4096", c_out[17:0]); end
        nCompared++; if (c_out[53:36] !== 18'd2048) begin nMismatched++; $display("FAIL mid_group1_old_c: got %0d expected 2048", c_out[53:36]); end
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        nCompared++; if (h_out !== '0) begin nMismatched++; $display("FAIL mid_reset_h: got %h expected 0", h_out); end
        nCompared++; if (c_out !== '0) begin nMismatched++; $display("FAIL mid_reset_c: got %h expected 0", c_out); end
        nCompared++; if (gates_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin nMismatched++; $display("FAIL mid_reset_ctrl: got ready=%b busy=%b valid=%b expected 1/0/0", gates_ready, busy, out_valid); end
        @(posedge clock); #1;
        reset = 1'b0;
        sendSample(rep(2048), rep(8192), rep(8192), rep(8192), 1'b0, lat, to);
        nCompared++; if (lat !== 8) begin nMismatched++; $display("FAIL post_reset_latency: got %0d expected 8", lat); end
        nCompared++; if (c_out !== rep(2048)) begin nMismatched++; $display("FAIL post_reset_c: got %h expected %h", c_out, rep(2048)); end
        nCompared++; if (h_out !== rep(2048)) begin nMismatched++; $display("FAIL post_reset_h: got %h expected %h", h_out, rep(2048)); end
        releaseOutput();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_zero();
        test_basic();
        test_negative();
        test_mixed();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lstm_elemwise_engine.md
Name: lstm_elemwise_engine

Overview:
- Parametrised LSTM cell-update engine. It takes the four gate pre-activation vectors (z, i, f, o) produced by the gate blocks and applies the nonlinearities. It then computes c_t = z*i + c_{t-1}*f and h_t = tanh(c_t)*o.
- The elementwise multiplies are time-shared over LANES multiplier lanes.
- Adds over the previous generation: valid/ready handshakes on both sides, internal cell-state storage with explicit clear, and saturating fixed-point arithmetic.

Parameters:
- HIDDEN_SZ, 16, number of hidden units (vector length).
- QN, 6, integer bits of the signed fixed-point format.
- QM, 11, fractional bits.
- LANES, 2, parallel multiplier lanes. HIDDEN_SZ % LANES must be 0; other values are an elaboration error.
- Derived constants:
  - BITWIDTH = QN+QM+1.
  - VEC_W = HIDDEN_SZ*BITWIDTH.
  - GROUPS = HIDDEN_SZ/LANES.
  - ONE = 1<<QM.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gate_z  in  VEC_W  z pre-activations, element k at [k*BITWIDTH +: BITWIDTH]
- gate_i  in  VEC_W  i pre-activations, same packing
- gate_f  in  VEC_W  f pre-activations, same packing
- gate_o  in  VEC_W  o pre-activations, same packing
- clear_state  in  1  sampled with accepted input; when set, c_{t-1} is taken as 0
- gates_valid  in  1  input vectors valid
- gates_ready  out  1  engine can accept
- h_out  out  VEC_W  h_t
- c_out  out  VEC_W  c_t (the stored cell state)
- out_valid  out  1  h_out/c_out valid
- out_ready  in  1  consumer accepts
- busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
  - Reset values: state=IDLE, gates_ready=1, out_valid=0, busy=0.
  - h_out, c_out, the internal c storage, the latched gate vectors and the group counter are all reset to 0.
- Accept: a transfer occurs on the edge where gates_valid && gates_ready.
  - gates_ready = (state==IDLE).
  - On accept: latch all four vectors and clear_state, set group counter g=0, go to ACT.
- FSM, one cycle per state:
  - IDLE -> ACT on accept.
  - ACT: register activations for elements g*LANES .. g*LANES+LANES-1. -> ZI.
  - ZI: register zi = mul(z,i) per lane. -> CF.
  - CF: write c_new = sat(zi + mul(c_prev,f)) into c storage and c_out for the group. -> HO.
    - c_prev = 0 if the latched clear_state is set, else the stored c.
  - HO: write h = mul(hard_tanh(c_new), o) into h_out for the group.
    - If g==GROUPS-1 -> DONE; else g<=g+1 and -> ACT.
  - DONE: out_valid=1. -> IDLE on out_ready.
- Latency: out_valid rises exactly 4*GROUPS clock edges after the accept edge.
- Activations (combinational, per lane):
  - hard_sigmoid(x) = clamp((x>>>2)+ONE/2, 0, ONE).
  - hard_tanh(x) = clamp(x, -ONE, ONE).
  - z uses hard_tanh; i, f, o use hard_sigmoid.
- mul(a,b): full 2*BITWIDTH signed product, arithmetic shift right by QM (truncate toward -inf), then saturate to [-(2^(BITWIDTH-1)), 2^(BITWIDTH-1)-1].
- sat(): the addition is done at BITWIDTH+1 bits and saturates to the same range. No wrap-around anywhere.
- Output hold: h_out and c_out change only during the group writes of an operation.
  - While out_valid=1 they are stable and gates_ready=0.
  - Backpressure of any length is allowed.
- Simultaneous events:
  - out_ready with gates_valid in DONE: the output handshake completes; the new input is accepted no earlier than the following cycle, in IDLE.
  - out_ready outside DONE is ignored.
- During an operation, h_out/c_out for groups not yet processed still show the previous sample's values.
- Reset mid-operation: immediate return to reset values. The partial results and the cell state are lost.

Decomposition:
- Shared package: BITWIDTH/VEC_W derivation, the ONE constant, and the sat and mul helper functions. The existing log2 function also moves there.
- One sub-module, pwl_act: parameters QN, QM, plus a mode input (0=sigmoid, 1=tanh). Combinational clamp unit, instantiated per lane for z/i/f/o and for tanh(c).

Test Plan:
All cases use HIDDEN_SZ=4, LANES=2, QN=6, QM=11 (ONE=2048).
- All gates 0, clear_state=1 -> c=0 and h=0 for all elements. out_valid asserts exactly 8 cycles after accept.
- gz=2048, gi=8192, gf=0, go=8192, clear_state=1 -> c=2048, h=2048. Repeat with clear_state=0 -> c=3072, h=2048.
- gz=2048, gi=gf=go=8192, clear_state=0, 70 consecutive samples -> c increases by 2048 per sample and saturates at 131071 from sample 64 onward. h stays at 2048.
- gz=-2048, gi=8192, gf=0, go=8192, clear_state=1 -> c=-2048, h=-2048 (negative path, truncation check).
- out_ready held low 5 cycles in DONE -> out_valid, h_out and c_out stay stable and gates_ready=0. A gates_valid pulse in the same cycle as out_ready is not accepted until the next cycle.
- Reset asserted during the second ACT state -> outputs immediately 0 and gates_ready=1. A following sample with clear_state=0 behaves as if c_prev=0.
